// File: rtl/frog_race_pkg.sv
// frog_race_pkg: shared state encoding, countdown light patterns and field width
package frog_race_pkg;
  typedef enum logic [1:0] {IDLE, COUNTDOWN, RACE, WIN} state_e;
  localparam int LIGHT_W = 4;
  localparam logic [LIGHT_W-1:0] THERM3 = 4'b0111;
  localparam logic [LIGHT_W-1:0] THERM2 = 4'b0011;
  localparam logic [LIGHT_W-1:0] THERM1 = 4'b0001;
  function automatic logic [LIGHT_W-1:0] therm(input logic [1:0] ph);
    return ph == 2'd3 ? THERM3 : ph == 2'd2 ? THERM2 : THERM1;
  endfunction
endpackage

// File: rtl/frog_race_core_lane.sv
// frog_lane: one player's edge detect, position, cooldown, lap count and false-start flag
module frog_lane
  import frog_race_pkg::*;
#(
  parameter int TRACK_LEN    = 18,
  parameter int HOP_COOLDOWN = 5_000_000,
  parameter int PENALTY_CYC  = 100_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         go,
  input  logic                         back,
  input  logic                         cdown,
  input  logic                         race_entry,
  input  logic                         active,
  input  logic                         clr,
  output logic [$clog2(TRACK_LEN)-1:0] pos_d,
  output logic [LIGHT_W-1:0]           laps_d,
  output logic [LIGHT_W-1:0]           laps_q
);
  localparam int POS_W = $clog2(TRACK_LEN);
  localparam int CD_W = $clog2((HOP_COOLDOWN > PENALTY_CYC ? HOP_COOLDOWN : PENALTY_CYC) + 1);
  logic go_q, back_q, fs_q, fs_d, go_p, back_p, wrap;
  logic [POS_W-1:0] pos_q;
  logic [CD_W-1:0] cd_q, cd_d;
  always_comb begin
    go_p = go & ~go_q;
    back_p = back & ~back_q;
    wrap = pos_q == POS_W'(TRACK_LEN - 2);
    pos_d = pos_q;
    laps_d = laps_q;
    cd_d = cd_q;
    fs_d = fs_q;
    if (clr) begin
      pos_d = '0;
      laps_d = '0;
      cd_d = '0;
      fs_d = 1'b0;
    end else if (cdown) begin
      fs_d = fs_q | go_p | back_p;
      cd_d = race_entry ? (fs_d ? CD_W'(PENALTY_CYC) : '0) : cd_q;
      fs_d = fs_d & ~race_entry;
    end else if (active) begin
      if (cd_q != '0) begin
        cd_d = cd_q - 1'b1;
      end else if (go_p && !back_p) begin
        pos_d = wrap ? '0 : pos_q + 1'b1;
        laps_d = (wrap && laps_q != 4'hf) ? laps_q + 4'd1 : laps_q;
        cd_d = CD_W'(HOP_COOLDOWN);
      end else if (back_p && !go_p && pos_q != '0) begin
        pos_d = pos_q - 1'b1;
        cd_d = CD_W'(HOP_COOLDOWN);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      go_q <= 1'b0;
      back_q <= 1'b0;
      fs_q <= 1'b0;
      pos_q <= '0;
      laps_q <= '0;
      cd_q <= '0;
    end else begin
      go_q <= go;
      back_q <= back;
      fs_q <= fs_d;
      pos_q <= pos_d;
      laps_q <= laps_d;
      cd_q <= cd_d;
    end
  end
endmodule

// File: rtl/frog_race_core.sv
// frog_race_core: N-player frog race with countdown, false-start penalty, laps and winner blink
module frog_race_core
  import frog_race_pkg::*;
#(
  parameter int NUM_PLAYERS  = 2,
  parameter int TRACK_LEN    = 18,
  parameter int LAPS_TO_WIN  = 3,
  parameter int PHASE_CYC    = 50_000_000,
  parameter int HOP_COOLDOWN = 5_000_000,
  parameter int PENALTY_CYC  = 100_000_000,
  parameter int BLINK_CYC    = 25_000_000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         go,
  input  logic [NUM_PLAYERS-1:0]         back,
  output logic [TRACK_LEN-1:0]           outview,
  output logic [LIGHT_W*NUM_PLAYERS-1:0] light,
  output logic [1:0]                     state,
  output logic                           winner_valid,
  output logic [2:0]                     winner_id
);
  localparam int POS_W = $clog2(TRACK_LEN);
  localparam int PC_W = $clog2(PHASE_CYC + 1);
  localparam int BC_W = $clog2(BLINK_CYC + 1);
  state_e state_q, state_d;
  logic start_q, start_p, race_entry, active, clr, win_any, blink_q, blink_d, wv_q;
  logic [1:0] phase_q, phase_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic [2:0] win_id, wid_q, wid_d;
  logic [TRACK_LEN-1:0] ov, outview_q, outview_d;
  logic [LIGHT_W*NUM_PLAYERS-1:0] light_q, light_d;
  logic [POS_W-1:0] pos_d [NUM_PLAYERS];
  logic [LIGHT_W-1:0] laps_d [NUM_PLAYERS];
  logic [LIGHT_W-1:0] laps_q [NUM_PLAYERS];
  assign start_p = start & ~start_q;
  assign race_entry = state_q == COUNTDOWN && pcnt_q == '0 && phase_q == 2'd1;
  assign active = state_q == RACE && !win_any;
  assign clr = state_q == WIN && start_p;
  for (genvar i = 0; i < NUM_PLAYERS; i++) begin : g_lane
    frog_lane #(
      .TRACK_LEN(TRACK_LEN),
      .HOP_COOLDOWN(HOP_COOLDOWN),
      .PENALTY_CYC(PENALTY_CYC)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .go(go[i]),
      .back(back[i]),
      .cdown(state_q == COUNTDOWN),
      .race_entry(race_entry),
      .active(active),
      .clr(clr),
      .pos_d(pos_d[i]),
      .laps_d(laps_d[i]),
      .laps_q(laps_q[i])
    );
  end
  always_comb begin
    win_any = 1'b0;
    win_id = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (laps_q[i] >= LIGHT_W'(LAPS_TO_WIN)) begin
        win_any = 1'b1;
        win_id = 3'(i);
      end
    end
  end
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pcnt_d = pcnt_q;
    bcnt_d = bcnt_q;
    blink_d = blink_q;
    wid_d = wid_q;
    case (state_q)
      IDLE: if (start_p) begin
        state_d = COUNTDOWN;
        phase_d = 2'd3;
        pcnt_d = PC_W'(PHASE_CYC - 1);
      end
      COUNTDOWN: begin
        state_d = race_entry ? RACE : COUNTDOWN;
        phase_d = pcnt_q == '0 ? phase_q - 2'd1 : phase_q;
        pcnt_d = pcnt_q == '0 ? PC_W'(PHASE_CYC - 1) : pcnt_q - 1'b1;
      end
      RACE: if (win_any) begin
        state_d = WIN;
        wid_d = win_id;
        blink_d = 1'b1;
        bcnt_d = BC_W'(BLINK_CYC - 1);
      end
      WIN: begin
        state_d = start_p ? IDLE : WIN;
        wid_d = start_p ? '0 : wid_q;
        blink_d = bcnt_q == '0 ? ~blink_q : blink_q;
        bcnt_d = bcnt_q == '0 ? BC_W'(BLINK_CYC - 1) : bcnt_q - 1'b1;
      end
    endcase
  end
  always_comb begin
    ov = '0;
    light_d = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      ov = ov | (TRACK_LEN'(1) << pos_d[i]);
      light_d[LIGHT_W*i +: LIGHT_W] = state_d == COUNTDOWN ? therm(phase_d) :
                                      state_d == IDLE ? '0 : laps_d[i];
    end
    outview_d = state_d == IDLE ? TRACK_LEN'(1) : state_d == WIN ? {TRACK_LEN{blink_d}} : ov;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      phase_q <= '0;
      pcnt_q <= '0;
      bcnt_q <= '0;
      blink_q <= 1'b0;
      wid_q <= '0;
      wv_q <= 1'b0;
      outview_q <= TRACK_LEN'(1);
      light_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      phase_q <= phase_d;
      pcnt_q <= pcnt_d;
      bcnt_q <= bcnt_d;
      blink_q <= blink_d;
      wid_q <= wid_d;
      wv_q <= state_d == WIN;
      outview_q <= outview_d;
      light_q <= light_d;
    end
  end
  assign state = state_q;
  assign outview = outview_q;
  assign light = light_q;
  assign winner_valid = wv_q;
  assign winner_id = wid_q;
endmodule

// File: tb/tb_frog_race_core.sv
// tb_frog_race_core: random and directed race stimulus checked cycle by cycle against an event-level model
module tb_frog_race_core;
  localparam int N = 2, T = 18, L = 2, P = 4, H = 2, PEN = 20, B = 3;
  logic clk = 1'b0;
  logic rst, start;
  logic [N-1:0] go, back;
  logic [T-1:0] outview;
  logic [4*N-1:0] light;
  logic [1:0] state;
  logic winner_valid;
  logic [2:0] winner_id;
  int n_chk, n_fail, e;
  int m_st, cd_edge, win_edge, m_wid;
  int m_pos [N];
  int m_laps [N];
  int m_ready [N];
  bit m_fs [N];
  bit pg [N];
  bit pb [N];
  bit ps;
  always #5 clk = ~clk;
  frog_race_core #(
    .NUM_PLAYERS(N), .TRACK_LEN(T), .LAPS_TO_WIN(L), .PHASE_CYC(P),
    .HOP_COOLDOWN(H), .PENALTY_CYC(PEN), .BLINK_CYC(B)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .go(go), .back(back),
    .outview(outview), .light(light), .state(state),
    .winner_valid(winner_valid), .winner_id(winner_id)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask
  function automatic logic [31:0] exp_ov();
    logic [T-1:0] v = '0;
    if (m_st == 0) return 32'd1;
    if (m_st == 3) return ((e - win_edge) / B) % 2 == 0 ? {T{1'b1}} : 32'd0;
    for (int i = 0; i < N; i++) v = v | (T'(1) << m_pos[i]);
    return 32'(v);
  endfunction
  function automatic logic [31:0] exp_light();
    logic [4*N-1:0] v = '0;
    for (int i = 0; i < N; i++)
      v[4*i +: 4] = m_st == 1 ? 4'((1 << (3 - (e - cd_edge) / P)) - 1) : m_st == 0 ? 4'd0 : 4'(m_laps[i]);
    return 32'(v);
  endfunction
  task automatic tick(input bit r, input bit s, input logic [N-1:0] g, input logic [N-1:0] b);
    bit gp [N];
    bit bp [N];
    bit sp, won;
    rst = r; start = s; go = g; back = b;
    @(posedge clk);
    e++;
    sp = s && !ps;
    ps = s && !r;
    for (int i = 0; i < N; i++) begin
      gp[i] = g[i] && !pg[i];
      bp[i] = b[i] && !pb[i];
      pg[i] = g[i] && !r;
      pb[i] = b[i] && !r;
    end
    if (r) begin
      m_st = 0; m_wid = 0;
      for (int i = 0; i < N; i++) begin m_pos[i] = 0; m_laps[i] = 0; m_fs[i] = 0; end
    end else if (m_st == 0) begin
      if (sp) begin m_st = 1; cd_edge = e; end
    end else if (m_st == 1) begin
      for (int i = 0; i < N; i++) if (gp[i] || bp[i]) m_fs[i] = 1;
      if (e - cd_edge == 3 * P) begin
        m_st = 2;
        for (int i = 0; i < N; i++) begin m_ready[i] = m_fs[i] ? e + PEN + 1 : e + 1; m_fs[i] = 0; end
      end
    end else if (m_st == 2) begin
      won = 0;
      for (int i = 0; i < N; i++) if (!won && m_laps[i] >= L) begin won = 1; m_wid = i; end
      if (won) begin m_st = 3; win_edge = e; end
      else for (int i = 0; i < N; i++) begin
        if (e >= m_ready[i] && gp[i] != bp[i]) begin
          if (gp[i]) begin
            m_pos[i]++;
            if (m_pos[i] == T - 1) begin m_pos[i] = 0; if (m_laps[i] < 15) m_laps[i]++; end
            m_ready[i] = e + H + 1;
          end else if (m_pos[i] > 0) begin
            m_pos[i]--;
            m_ready[i] = e + H + 1;
          end
        end
      end
    end else if (sp) begin
      m_st = 0; m_wid = 0;
      for (int i = 0; i < N; i++) begin m_pos[i] = 0; m_laps[i] = 0; end
    end
    #1;
    chk("state", 32'(state), 32'(m_st));
    chk("outview", 32'(outview), exp_ov());
    chk("light", 32'(light), exp_light());
    chk("winner_valid", 32'(winner_valid), 32'(m_st == 3));
    chk("winner_id", 32'(winner_id), m_st == 3 ? 32'(m_wid) : 32'd0);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(0, 0, '0, '0);
  endtask
  task automatic go_train(input logic [N-1:0] mask, input int hops);
    for (int k = 0; k < hops; k++) begin
      tick(0, 0, mask, '0);
      idle(2);
    end
  endtask
  task automatic start_race();
    tick(0, 1, '0, '0);
    idle(13);
  endtask
  initial begin
    logic [N-1:0] g, b;
    bit r, s;
    n_chk = 0; n_fail = 0; e = 0; m_st = 0; m_wid = 0; ps = 0;
    for (int i = 0; i < N; i++) begin m_pos[i] = 0; m_laps[i] = 0; m_fs[i] = 0; pg[i] = 0; pb[i] = 0; m_ready[i] = 0; end
    repeat (3) tick(1, 0, '0, '0);
    idle(2);
    start_race();
    go_train(2'b01, 3);
    tick(0, 0, 2'b01, '0); tick(0, 0, '0, '0); tick(0, 0, 2'b01, '0); idle(3);
    tick(0, 0, '0, 2'b10); idle(3);
    go_train(2'b10, 5);
    tick(0, 0, 2'b10, 2'b10); idle(3);
    tick(0, 1, '0, '0); idle(2);
    go_train(2'b01, 40);
    idle(8);
    tick(0, 1, '0, '0);
    idle(2);
    tick(0, 1, '0, '0);
    idle(3);
    tick(0, 0, 2'b10, '0);
    idle(9);
    for (int k = 0; k < 30; k++) tick(0, 0, 2'(k % 2 == 0 ? 2'b11 : 2'b00), '0);
    tick(1, 0, '0, '0);
    idle(2);
    start_race();
    go_train(2'b11, 34);
    idle(10);
    tick(0, 1, '0, '0);
    idle(2);
    start_race();
    go_train(2'b11, 6);
    tick(1, 0, 2'b11, '0);
    idle(2);
    for (int c = 0; c < 6000; c++) begin
      r = $urandom_range(0, 2999) == 0;
      s = (m_st == 0 || m_st == 3) ? $urandom_range(0, 7) == 0 : $urandom_range(0, 99) == 0;
      for (int i = 0; i < N; i++) begin
        g[i] = 1'($urandom_range(0, 1));
        b[i] = $urandom_range(0, 5) == 0;
      end
      tick(r, s, g, b);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
